pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-flow controller that sits between the decode stage and the ProgramCounter. It sequences every PC update: increment, relative branch, absolute jump, call/return through a small return-address stack, interrupt entry and halt. It accepts one flow operation per handshake. It drives the ProgramCounter's LoadEnable/LoadValue/OffsetEnable/Offset controls as registered, single-cycle pulses.

## Interface
- STACK_DEPTH, 4: return-address stack entries (power of two, 2–16)
- RESET_VECTOR, 16'h0000: PC loaded after reset release and on stack underflow
- IRQ_VECTOR, 16'h0004: PC loaded on interrupt entry

Ports:
- Clock  in  1  system clock, all state on posedge
- nReset  in  1  asynchronous, active-low reset
- CounterValue  in  16  current PC from ProgramCounter
- InstrValid  in  1  decode presents a flow op
- InstrReady  out  1  sequencer accepts op this cycle
- Op  in  3  flow op code (package enum: OP_SEQ, OP_BRANCH, OP_JUMP, OP_CALL, OP_RET, OP_HALT)
- Cond  in  1  branch condition, used only with OP_BRANCH
- Target  in  16  absolute target for OP_JUMP/OP_CALL
- Disp  in  9 signed  displacement for OP_BRANCH
- IrqReq  in  1  level interrupt request
- Resume  in  1  leave HALT
- IrqAck  out  1  one-cycle pulse on interrupt entry
- LoadEnable  out  1  to ProgramCounter
- LoadValue  out  16  to ProgramCounter
- OffsetEnable  out  1  to ProgramCounter
- Offset  out  9 signed  to ProgramCounter
- StackFault  out  1  sticky, set on stack overflow or underflow

## Operation
- States: S_BOOT, S_IDLE, S_EXEC, S_HALT.
- S_BOOT: first cycle after reset release. Drive LoadEnable=1 and LoadValue=RESET_VECTOR, then go to S_IDLE.
- S_IDLE: InstrReady=1 unless an interrupt is being taken.
  - An interrupt is taken when IrqReq=1 and IrqMask=0. It has priority over InstrValid (InstrReady=0 that cycle).
  - On interrupt: push CounterValue, load IRQ_VECTOR, pulse IrqAck, set IrqMask.
  - A handshake (InstrValid & InstrReady) registers the op and goes to S_EXEC.
- S_EXEC: exactly one cycle driving the control pulse, then S_IDLE (S_HALT for OP_HALT). Per op:
  - OP_SEQ: OffsetEnable=1, Offset=+1.
  - OP_BRANCH: OffsetEnable=1, Offset=Disp if Cond else +1.
  - OP_JUMP: LoadEnable=1, LoadValue=Target.
  - OP_CALL: push CounterValue+1, then load Target.
  - OP_RET: pop into LoadValue, LoadEnable=1. Clear IrqMask.
  - OP_HALT: no pulse.
- S_HALT: InstrReady=0. Resume=1 returns to S_IDLE. An unmasked IrqReq takes the interrupt (return address = CounterValue) and returns to S_IDLE.
- Interrupt entry from S_IDLE/S_HALT drives its load pulse in the same registered manner as S_EXEC.
- LoadEnable and OffsetEnable are never both 1. All control outputs are 0 outside their pulse cycle.
- Stack rules:
  - Push when full: push discarded (existing entries kept), StackFault set, target still loaded.
  - Pop when empty: LoadValue=RESET_VECTOR, StackFault set.
- Arithmetic: CounterValue+1 wraps modulo 2^16. Disp is sign-carried unchanged (−256..+255).

## Timing
- Handshake at edge N: control pulse high during cycle N+1, PC updated at edge N+2. Next op accepted at edge N+2 earliest. Throughput is one op per 2 cycles.
- Interrupt accepted at edge N: IrqAck and the load pulse both high during cycle N+1.
- Stack push/pop commit at the edge that ends the pulse cycle.
- Reset values: InstrReady=0, IrqAck=0, LoadEnable=0, LoadValue=0, OffsetEnable=0, Offset=0, StackFault=0. Stack is empty, IrqMask=0, state=S_BOOT.
- nReset asserted mid-operation clears everything immediately and asynchronously. Any in-flight pulse is dropped.
- IrqReq arriving in the same cycle as InstrValid in S_IDLE: the interrupt wins and the op stays pending (InstrReady=0).

## Structure
- Package pc_seq_pkg holds: the op_t enum, the state_t enum, and the PC_W=16 and OFF_W=9 constants.
- Sub-module return_stack (parameter STACK_DEPTH):
  - ports: push, pop, push data, top, full, empty
  - LIFO with pointer
  - async active-low reset to empty

## Test plan
- Reset release: nReset low→high → S_BOOT pulse LoadEnable=1, LoadValue=16'h0000 for one cycle; InstrReady=1 on the next cycle.
- OP_BRANCH Disp=−3, Cond=1, CounterValue=16'h0010 → OffsetEnable=1, Offset=9'h1FD one cycle after the handshake. Repeat with Cond=0 → Offset=+1.
- OP_CALL Target=16'h0100 at CounterValue=16'h0020, then OP_RET → LoadValue=16'h0100, then LoadValue=16'h0021.
- Five nested calls with STACK_DEPTH=4 → StackFault=1 on the fifth; four RETs return the first four addresses in reverse; a fifth RET loads RESET_VECTOR.
- IrqReq=1 simultaneous with InstrValid (OP_JUMP) at CounterValue=16'h0040 → IrqAck pulse, LoadValue=16'h0004, jump stays pending. A later OP_RET → LoadValue=16'h0040 and IrqMask cleared.
- OP_HALT then nReset low mid-halt → all outputs 0 immediately. A separate run: OP_HALT then Resume=1 → InstrReady=1 the next cycle.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and widths for the program-flow sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package pc_seq_pkg;

   localparam int PC_W  = 16;
   localparam int OFF_W = 9;

   typedef enum logic [2:0] {
      OP_SEQ    = 3'd0,
      OP_BRANCH = 3'd1,
      OP_JUMP   = 3'd2,
      OP_CALL   = 3'd3,
      OP_RET    = 3'd4,
      OP_HALT   = 3'd5
   } op_t;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_IDLE = 2'd1,
      S_EXEC = 2'd2,
      S_HALT = 2'd3
   } state_t;

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO: pointer-indexed register file with full/empty flags.
// Latency: push/pop commit at the clock edge; top_o is combinational from state.
// Backpressure: none; push when full and pop when empty are ignored (caller flags the fault).
module return_stack
   import pc_seq_pkg::*;
#(
   parameter int STACK_DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [PC_W-1:0] push_dat_i,
   output logic [PC_W-1:0] top_o,
   output logic            full_o,
   output logic            empty_o
);

   localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [PW:0]     cnt_q, cnt_d;
   logic [PW:0]     cnt_m1;
   logic [PC_W-1:0] mem_q [STACK_DEPTH];
   logic [PW-1:0]   wr_idx;
   logic [PW-1:0]   top_idx;
   logic            do_push;

   assign full_o  = (cnt_q == (PW+1)'(STACK_DEPTH));
   assign empty_o = (cnt_q == '0);
   assign cnt_m1  = cnt_q - (PW+1)'(1);
   assign wr_idx  = cnt_q[PW-1:0];
   assign top_idx = cnt_m1[PW-1:0];
   assign top_o   = mem_q[top_idx];
   assign do_push = push_i && !full_o;

   // Occupancy update; overflowing pushes and underflowing pops leave the stack untouched.
   always_comb begin
      cnt_d = cnt_q;
      if (do_push) begin
         cnt_d = cnt_q + (PW+1)'(1);
      end else if (pop_i && !empty_o) begin
         cnt_d = cnt_m1;
      end
   end

   // Pointer and entry storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         if (do_push) begin
            mem_q[wr_idx] <= push_dat_i;
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-flow sequencer: turns decoded flow ops and interrupts into ProgramCounter load/offset pulses.
// Latency: control pulse one cycle after handshake/interrupt accept; one op per two cycles.
// Backpressure: InstrReady low outside S_IDLE and whenever an unmasked interrupt is being taken.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              STACK_DEPTH  = 4,
   parameter logic [PC_W-1:0] RESET_VECTOR = 16'h0000,
   parameter logic [PC_W-1:0] IRQ_VECTOR   = 16'h0004
) (
   input  logic                    Clock,
   input  logic                    nReset,
   input  logic [PC_W-1:0]         CounterValue,
   input  logic                    InstrValid,
   output logic                    InstrReady,
   input  logic [2:0]              Op,
   input  logic                    Cond,
   input  logic [PC_W-1:0]         Target,
   input  logic signed [OFF_W-1:0] Disp,
   input  logic                    IrqReq,
   input  logic                    Resume,
   output logic                    IrqAck,
   output logic                    LoadEnable,
   output logic [PC_W-1:0]         LoadValue,
   output logic                    OffsetEnable,
   output logic signed [OFF_W-1:0] Offset,
   output logic                    StackFault
);

   state_t                  state_q, state_d;
   logic                    le_q, le_d;
   logic [PC_W-1:0]         lv_q, lv_d;
   logic                    oe_q, oe_d;
   logic signed [OFF_W-1:0] off_q, off_d;
   logic                    ack_q, ack_d;
   logic                    fault_q, fault_d;
   logic                    mask_q, mask_d;
   logic                    push_q, push_d;   // push commits at the end of the pulse cycle
   logic                    pop_q, pop_d;     // pop commits at the end of the pulse cycle
   logic [PC_W-1:0]         pdat_q, pdat_d;
   logic                    halt_q, halt_d;   // pulse cycle is followed by S_HALT

   op_t             op_in;
   logic            irq_take;
   logic            enter_irq;
   logic            accept;
   logic            stk_push;
   logic            stk_pop;
   logic [PC_W-1:0] stk_top;
   logic            stk_full;
   logic            stk_empty;

   assign op_in     = op_t'(Op);
   assign irq_take  = IrqReq && !mask_q;
   assign enter_irq = irq_take && ((state_q == S_IDLE) || (state_q == S_HALT));
   assign accept    = (state_q == S_IDLE) && InstrValid && !irq_take;
   assign stk_push  = (state_q == S_EXEC) && push_q;
   assign stk_pop   = (state_q == S_EXEC) && pop_q;

   assign InstrReady   = (state_q == S_IDLE) && !irq_take;
   assign IrqAck       = ack_q;
   assign LoadEnable   = le_q;
   assign LoadValue    = lv_q;
   assign OffsetEnable = oe_q;
   assign Offset       = off_q;
   assign StackFault   = fault_q;

   return_stack #(
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk_i      (Clock),
      .rst_ni     (nReset),
      .push_i     (stk_push),
      .pop_i      (stk_pop),
      .push_dat_i (pdat_q),
      .top_o      (stk_top),
      .full_o     (stk_full),
      .empty_o    (stk_empty)
   );

   // Next state and next pulse values; pulses default to zero so each lasts exactly one cycle.
   // Stack overflow/underflow is detected at accept time (stack is stable until the commit)
   // so StackFault rises together with the offending pulse.
   always_comb begin
      state_d = state_q;
      le_d    = 1'b0;
      lv_d    = '0;
      oe_d    = 1'b0;
      off_d   = '0;
      ack_d   = 1'b0;
      fault_d = fault_q;
      mask_d  = mask_q;
      push_d  = 1'b0;
      pop_d   = 1'b0;
      pdat_d  = pdat_q;
      halt_d  = 1'b0;

      case (state_q)
         S_BOOT: begin
            le_d    = 1'b1;
            lv_d    = RESET_VECTOR;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = halt_q ? S_HALT : S_IDLE;
            if (pop_q) begin
               mask_d = 1'b0;
            end
         end
         S_IDLE: begin
            if (accept) begin
               state_d = S_EXEC;
               case (op_in)
                  OP_SEQ: begin
                     oe_d  = 1'b1;
                     off_d = OFF_W'(1);
                  end
                  OP_BRANCH: begin
                     oe_d  = 1'b1;
                     off_d = Cond ? Disp : OFF_W'(1);
                  end
                  OP_JUMP: begin
                     le_d = 1'b1;
                     lv_d = Target;
                  end
                  OP_CALL: begin
                     le_d   = 1'b1;
                     lv_d   = Target;
                     push_d = 1'b1;
                     pdat_d = CounterValue + PC_W'(1);
                     if (stk_full) begin
                        fault_d = 1'b1;
                     end
                  end
                  OP_RET: begin
                     le_d  = 1'b1;
                     pop_d = 1'b1;
                     if (stk_empty) begin
                        lv_d    = RESET_VECTOR;
                        fault_d = 1'b1;
                     end else begin
                        lv_d = stk_top;
                     end
                  end
                  OP_HALT: begin
                     halt_d = 1'b1;
                  end
                  default: begin
                     // Unassigned op codes are consumed without a pulse.
                  end
               endcase
            end
         end
         S_HALT: begin
            if (!enter_irq && Resume) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase

      if (enter_irq) begin
         state_d = S_EXEC;
         le_d    = 1'b1;
         lv_d    = IRQ_VECTOR;
         ack_d   = 1'b1;
         mask_d  = 1'b1;
         push_d  = 1'b1;
         pdat_d  = CounterValue;
         if (stk_full) begin
            fault_d = 1'b1;
         end
      end
   end

   // State and registered outputs; reset drops any pulse in flight.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= S_BOOT;
         le_q    <= 1'b0;
         lv_q    <= '0;
         oe_q    <= 1'b0;
         off_q   <= '0;
         ack_q   <= 1'b0;
         fault_q <= 1'b0;
         mask_q  <= 1'b0;
         push_q  <= 1'b0;
         pop_q   <= 1'b0;
         pdat_q  <= '0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         le_q    <= le_d;
         lv_q    <= lv_d;
         oe_q    <= oe_d;
         off_q   <= off_d;
         ack_q   <= ack_d;
         fault_q <= fault_d;
         mask_q  <= mask_d;
         push_q  <= push_d;
         pop_q   <= pop_d;
         pdat_q  <= pdat_d;
         halt_q  <= halt_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: transaction-level model with a queue-based return stack and a
// per-cycle compare process, plus directed scenarios with literal expectations and random traffic.
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   localparam int              DEPTH = 4;
   localparam logic [15:0]     RV    = 16'h0000;
   localparam logic [15:0]     IV    = 16'h0004;

   logic               Clock;
   logic               nReset;
   logic [15:0]        CounterValue;
   logic               InstrValid;
   logic               InstrReady;
   logic [2:0]         Op;
   logic               Cond;
   logic [15:0]        Target;
   logic signed [8:0]  Disp;
   logic               IrqReq;
   logic               Resume;
   logic               IrqAck;
   logic               LoadEnable;
   logic [15:0]        LoadValue;
   logic               OffsetEnable;
   logic signed [8:0]  Offset;
   logic               StackFault;

   pc_sequencer #(
      .STACK_DEPTH  (DEPTH),
      .RESET_VECTOR (RV),
      .IRQ_VECTOR   (IV)
   ) dut (
      .Clock        (Clock),
      .nReset       (nReset),
      .CounterValue (CounterValue),
      .InstrValid   (InstrValid),
      .InstrReady   (InstrReady),
      .Op           (Op),
      .Cond         (Cond),
      .Target       (Target),
      .Disp         (Disp),
      .IrqReq       (IrqReq),
      .Resume       (Resume),
      .IrqAck       (IrqAck),
      .LoadEnable   (LoadEnable),
      .LoadValue    (LoadValue),
      .OffsetEnable (OffsetEnable),
      .Offset       (Offset),
      .StackFault   (StackFault)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic        le;
      logic [15:0] lv;
      logic        oe;
      logic [8:0]  off;
      logic        ack;
      logic        flt;
   } pulse_t;

   int checks = 0;
   int errors = 0;

   // Model state (what the sequencer must have done so far, in transaction terms).
   logic [15:0] stk [$];
   logic [15:0] pc;
   bit          booting, pulse_now, halted, halt_after, mask_m, fault_m, accepted;
   pulse_t      exp_cur, exp_next;
   bit          exp_rdy;
   bit          chk_en;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge Clock) begin
      if (chk_en) begin
         cmp("InstrReady",   32'(InstrReady),   32'(exp_rdy));
         cmp("LoadEnable",   32'(LoadEnable),   32'(exp_cur.le));
         cmp("LoadValue",    32'(LoadValue),    32'(exp_cur.lv));
         cmp("OffsetEnable", 32'(OffsetEnable), 32'(exp_cur.oe));
         cmp("Offset",       32'($unsigned(Offset)), 32'(exp_cur.off));
         cmp("IrqAck",       32'(IrqAck),       32'(exp_cur.ack));
         cmp("StackFault",   32'(StackFault),   32'(exp_cur.flt));
      end
   end

   task automatic push_m(input logic [15:0] v);
      if (stk.size() < DEPTH) stk.push_back(v);
      else fault_m = 1'b1;
   endtask

   // Decide what the coming clock edge does given the inputs now applied.
   task automatic decide();
      pulse_t n;
      bit     irq;
      n        = '0;
      accepted = 1'b0;
      exp_rdy  = 1'b0;
      if (!nReset) begin
         booting = 1'b1; pulse_now = 1'b0; halted = 1'b0; halt_after = 1'b0;
         mask_m = 1'b0; fault_m = 1'b0; stk.delete();
      end else begin
         irq = IrqReq && !mask_m;
         if (booting) begin
            n.le = 1'b1; n.lv = RV; booting = 1'b0; pulse_now = 1'b1;
         end else if (pulse_now) begin
            pulse_now = 1'b0;
            if (halt_after) halted = 1'b1;
            halt_after = 1'b0;
         end else begin
            if (!halted) exp_rdy = !irq;
            if (irq) begin
               push_m(pc);
               n.le = 1'b1; n.lv = IV; n.ack = 1'b1;
               mask_m = 1'b1; halted = 1'b0; pulse_now = 1'b1;
            end else if (halted) begin
               if (Resume) halted = 1'b0;
            end else if (InstrValid) begin
               accepted  = 1'b1;
               pulse_now = 1'b1;
               case (op_t'(Op))
                  OP_SEQ:    begin n.oe = 1'b1; n.off = 9'd1; end
                  OP_BRANCH: begin n.oe = 1'b1; n.off = Cond ? Disp : 9'd1; end
                  OP_JUMP:   begin n.le = 1'b1; n.lv = Target; end
                  OP_CALL:   begin push_m(pc + 16'd1); n.le = 1'b1; n.lv = Target; end
                  OP_RET: begin
                     n.le = 1'b1;
                     if (stk.size() == 0) begin n.lv = RV; fault_m = 1'b1; end
                     else n.lv = stk.pop_back();
                     mask_m = 1'b0;
                  end
                  OP_HALT:   halt_after = 1'b1;
                  default:   ;
               endcase
            end
         end
      end
      n.flt    = fault_m;
      exp_next = n;
   endtask

   // One clock: predict, advance, then let the ProgramCounter follow the pulse that just ended.
   task automatic tick();
      decide();
      @(posedge Clock);
      #1;
      if (exp_cur.le) pc = exp_cur.lv;
      else if (exp_cur.oe) pc = pc + {{7{exp_cur.off[8]}}, exp_cur.off};
      exp_cur      = exp_next;
      CounterValue = pc;
   endtask

   // Present an op until the model accepts it; returns inside the pulse cycle.
   task automatic issue(input logic [2:0] op, input logic c, input logic [15:0] t, input logic [8:0] d);
      bit got;
      got = 1'b0;
      Op = op; Cond = c; Target = t; Disp = d; InstrValid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (accepted) begin
            got = 1'b1;
            break;
         end
      end
      InstrValid = 1'b0;
      if (!got) cmp("accept_timeout", 32'(got), 32'd1);
   endtask

   initial begin
      Clock = 1'b0; nReset = 1'b0;
      InstrValid = 1'b0; Op = '0; Cond = 1'b0; Target = '0; Disp = '0;
      IrqReq = 1'b0; Resume = 1'b0;
      pc = '0; CounterValue = '0;
      booting = 1'b1; pulse_now = 1'b0; halted = 1'b0; halt_after = 1'b0;
      mask_m = 1'b0; fault_m = 1'b0; accepted = 1'b0;
      exp_cur = '0; exp_next = '0; exp_rdy = 1'b0; chk_en = 1'b1;

      repeat (2) @(posedge Clock);
      #1;
      cmp("rst_LoadEnable", 32'(LoadEnable), 32'd0);
      cmp("rst_InstrReady", 32'(InstrReady), 32'd0);
      tick();

      // Boot pulse then ready.
      nReset = 1'b1;
      tick();
      cmp("boot_le", 32'(LoadEnable), 32'd1);
      cmp("boot_lv", 32'(LoadValue), 32'h0000);
      cmp("boot_rdy", 32'(InstrReady), 32'd0);
      tick();
      cmp("boot_then_rdy", 32'(InstrReady), 32'd1);

      // Branch taken / not taken at 0x0010.
      issue(3'(OP_JUMP), 1'b0, 16'h0010, 9'd0); tick();
      cmp("pc_at_0010", 32'(CounterValue), 32'h0010);
      issue(3'(OP_BRANCH), 1'b1, 16'h0000, 9'h1FD);
      cmp("br_taken_oe", 32'(OffsetEnable), 32'd1);
      cmp("br_taken_off", 32'($unsigned(Offset)), 32'h1FD);
      cmp("br_taken_le", 32'(LoadEnable), 32'd0);
      tick();
      issue(3'(OP_BRANCH), 1'b0, 16'h0000, 9'h1FD);
      cmp("br_not_off", 32'($unsigned(Offset)), 32'h001);
      tick();

      // Call/return at 0x0020.
      issue(3'(OP_JUMP), 1'b0, 16'h0020, 9'd0); tick();
      issue(3'(OP_CALL), 1'b0, 16'h0100, 9'd0);
      cmp("call_lv", 32'(LoadValue), 32'h0100);
      tick();
      issue(3'(OP_RET), 1'b0, 16'h0000, 9'd0);
      cmp("ret_lv", 32'(LoadValue), 32'h0021);
      tick();

      // Five nested calls on a four-deep stack.
      issue(3'(OP_JUMP), 1'b0, 16'h0300, 9'd0); tick();
      for (int i = 0; i < 5; i++) begin
         issue(3'(OP_CALL), 1'b0, 16'h0400 + 16'(i) * 16'h0100, 9'd0);
         if (i == 3) cmp("fault_before_fifth", 32'(StackFault), 32'd0);
         if (i == 4) begin
            cmp("fault_on_fifth", 32'(StackFault), 32'd1);
            cmp("fifth_call_lv", 32'(LoadValue), 32'h0800);
         end
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         logic [15:0] want;
         want = (i == 4) ? RV : (16'h0601 - 16'(i) * 16'h0100);
         issue(3'(OP_RET), 1'b0, 16'h0000, 9'd0);
         cmp("nested_ret_lv", 32'(LoadValue), 32'(want));
         tick();
      end

      // Interrupt beats a simultaneous jump at 0x0040.
      issue(3'(OP_JUMP), 1'b0, 16'h0040, 9'd0); tick();
      Op = 3'(OP_JUMP); Target = 16'h1234; InstrValid = 1'b1; IrqReq = 1'b1;
      #1;
      cmp("irq_blocks_rdy", 32'(InstrReady), 32'd0);
      tick();
      IrqReq = 1'b0;
      cmp("irq_ack", 32'(IrqAck), 32'd1);
      cmp("irq_lv", 32'(LoadValue), 32'h0004);
      tick();
      cmp("jump_pending", 32'(InstrReady), 32'd1);
      issue(3'(OP_JUMP), 1'b0, 16'h1234, 9'd0);
      cmp("pending_jump_lv", 32'(LoadValue), 32'h1234);
      tick();
      issue(3'(OP_RET), 1'b0, 16'h0000, 9'd0);
      cmp("irq_ret_lv", 32'(LoadValue), 32'h0040);
      tick();
      IrqReq = 1'b1;
      #1;
      cmp("mask_cleared", 32'(InstrReady), 32'd0);
      tick();
      IrqReq = 1'b0;
      cmp("irq_again_ack", 32'(IrqAck), 32'd1);
      tick();

      // Halt then resume.
      issue(3'(OP_HALT), 1'b0, 16'h0000, 9'd0);
      cmp("halt_no_pulse", 32'(LoadEnable | OffsetEnable), 32'd0);
      tick();
      cmp("halted_rdy", 32'(InstrReady), 32'd0);
      Resume = 1'b1; tick(); Resume = 1'b0;
      cmp("resume_rdy", 32'(InstrReady), 32'd1);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         int r;
         r          = int'($urandom_range(0, 11));
         InstrValid = 1'($urandom_range(0, 1));
         Op         = (r < 10) ? 3'(r % 5) : 3'(OP_HALT);
         Cond       = 1'($urandom_range(0, 1));
         Target     = 16'($urandom);
         Disp       = 9'($urandom);
         IrqReq     = ($urandom_range(0, 9) == 0);
         Resume     = ($urandom_range(0, 3) == 0);
         tick();
      end
      InstrValid = 1'b0; IrqReq = 1'b0; Resume = 1'b1;
      repeat (3) tick();
      Resume = 1'b0;

      // Asynchronous reset while halted.
      issue(3'(OP_HALT), 1'b0, 16'h0000, 9'd0);
      tick();
      cmp("halt2_rdy", 32'(InstrReady), 32'd0);
      #1;
      nReset = 1'b0;
      exp_cur = '0; exp_rdy = 1'b0;
      #1;
      cmp("arst_rdy",   32'(InstrReady),   32'd0);
      cmp("arst_ack",   32'(IrqAck),       32'd0);
      cmp("arst_le",    32'(LoadEnable),   32'd0);
      cmp("arst_lv",    32'(LoadValue),    32'd0);
      cmp("arst_oe",    32'(OffsetEnable), 32'd0);
      cmp("arst_off",   32'($unsigned(Offset)), 32'd0);
      cmp("arst_fault", 32'(StackFault),   32'd0);
      tick();
      nReset = 1'b1;
      tick();
      cmp("reboot_le", 32'(LoadEnable), 32'd1);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
